// File: rtl/fetch_stage_pkg.sv
// ---------------------------------------------------------------------------
// fetch_stage_pkg
// Shared definitions for the instruction-fetch stage of the 5-stage RISC-V
// core: default address width, reset PC, the NOP used for bubbles/flushes,
// and the fetch FSM state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package fetch_stage_pkg;

  // Defaults for the fetch_stage parameters of the same base name
  localparam int          FETCH_XLEN      = 32;
  localparam logic [31:0] FETCH_RESET_PC  = 32'h0000_0000;
  // ADDI x0,x0,0
  localparam logic [31:0] FETCH_NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    DROP = 3'd4
  } fetch_state_e;

endpackage : fetch_stage_pkg

// File: rtl/fetch_stage_if_id_reg.sv
// ---------------------------------------------------------------------------
// fetch_stage_if_id_reg
// IF/ID pipeline register: holds the PC, instruction word and valid flag of
// the instruction handed to decode. Flush has priority over write-enable.
//
// Ports:
//   clock, reset  rising-edge clock, async active-high reset
//   we_i          load pc_i/instr_i/valid_i this cycle
//   flush_i       squash: instr <- NOP_INSTR, valid <- 0 (pc kept)
//   pc_i          PC of the incoming instruction
//   instr_i       incoming instruction word
//   valid_i       incoming valid flag (0 for a bubble)
//   pc_o          registered PC
//   instr_o       registered instruction
//   valid_o       registered valid flag
// ---------------------------------------------------------------------------
module fetch_stage_if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter int          XLEN      = FETCH_XLEN,
  parameter logic [31:0] NOP_INSTR = FETCH_NOP_INSTR
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            we_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [31:0]     instr_i,
  input  logic            valid_i,
  output logic [XLEN-1:0] pc_o,
  output logic [31:0]     instr_o,
  output logic            valid_o
);

  logic [XLEN-1:0] pc_q;
  logic [31:0]     instr_q;
  logic            valid_q;

  // A flush must win over a simultaneous write so that a squashed
  // instruction can never reach decode.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (we_i) begin
      pc_q    <= pc_i;
      instr_q <= instr_i;
      valid_q <= valid_i;
    end
  end

  assign pc_o    = pc_q;
  assign instr_o = instr_q;
  assign valid_o = valid_q;

endmodule : fetch_stage_if_id_reg

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage of the 5-stage RISC-V core. Holds the PC, issues
// single-outstanding requests to instruction memory, buffers a response that
// decode is not yet ready for, and owns the IF/ID register. Obeys PCWrite /
// if_id_write from the hazard unit and redirects on a branch flush from EX.
//
// Optional feature macro: FETCH_PERF_CNT_EN
//   defined   -> adds saturating counters fetch_stall_cnt and flush_cnt
//   undefined -> no counter ports or logic
//
// Ports:
//   clock, reset     rising-edge clock, async active-high reset
//   enable           0 freezes all state
//   PCWrite          0 holds the PC
//   if_id_write      0 holds the IF/ID register
//   if_id_flush      redirect to branch_target and squash
//   branch_target    redirect PC
//   imem_req/addr    request valid / address to instruction memory
//   imem_ready       request accepted when imem_req & imem_ready
//   imem_rvalid/rdata one-cycle response valid / instruction
//   if_id_pc/instr/valid  IF/ID register contents
//   fetch_stall      IF/ID was loaded with a bubble due to memory latency
//   fetch_stall_cnt  (optional) enabled cycles with fetch_stall=1
//   flush_cnt        (optional) enabled cycles with if_id_flush=1
// ---------------------------------------------------------------------------
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int              XLEN      = FETCH_XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = FETCH_RESET_PC,
  parameter logic [31:0]     NOP_INSTR = FETCH_NOP_INSTR
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic            PCWrite,
  input  logic            if_id_write,
  input  logic            if_id_flush,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] if_id_pc,
  output logic [31:0]     if_id_instr,
  output logic            if_id_valid,
  output logic            fetch_stall
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     fetch_stall_cnt,
  output logic [31:0]     flush_cnt
`endif
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     buf_q, buf_d;
  logic            fetch_stall_q, fetch_stall_d;

  logic            ifid_we;
  logic            ifid_flush;
  logic [31:0]     ifid_instr;
  logic            ifid_valid;

  // State, PC, response buffer and stall flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      buf_q         <= NOP_INSTR;
      fetch_stall_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      buf_q         <= buf_d;
      fetch_stall_q <= fetch_stall_d;
    end
  end

  // Next-state and IF/ID control. Everything holds while enable is low.
  // A flush overrides the hazard controls; where a response is still in
  // flight for the squashed PC we park in DROP to swallow it.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    buf_d         = buf_q;
    fetch_stall_d = fetch_stall_q;
    ifid_we       = 1'b0;
    ifid_flush    = 1'b0;
    ifid_instr    = buf_q;
    ifid_valid    = 1'b1;

    if (enable) begin
      fetch_stall_d = 1'b0;
      if (if_id_flush) begin
        pc_d       = branch_target;
        buf_d      = NOP_INSTR;
        ifid_flush = 1'b1;
        case (state_q)
          WAIT:    state_d = imem_rvalid ? REQ : DROP;
          REQ:     state_d = imem_ready ? DROP : REQ;
          DROP:    state_d = imem_rvalid ? REQ : DROP;
          default: state_d = REQ;
        endcase
      end else begin
        case (state_q)
          IDLE: state_d = REQ;

          REQ: begin
            if (imem_ready) state_d = WAIT;
            // Decode wants an instruction but none is available: bubble.
            if (if_id_write) begin
              ifid_we       = 1'b1;
              ifid_instr    = NOP_INSTR;
              ifid_valid    = 1'b0;
              fetch_stall_d = 1'b1;
            end
          end

          WAIT: begin
            if (imem_rvalid) begin
              buf_d = imem_rdata;
              if (if_id_write) begin
                ifid_we    = 1'b1;
                ifid_instr = imem_rdata;
                if (PCWrite) pc_d = pc_q + PC_STEP;
                state_d = REQ;
              end else begin
                state_d = HOLD;
              end
            end else if (if_id_write) begin
              ifid_we       = 1'b1;
              ifid_instr    = NOP_INSTR;
              ifid_valid    = 1'b0;
              fetch_stall_d = 1'b1;
            end
          end

          HOLD: begin
            if (if_id_write) begin
              ifid_we    = 1'b1;
              ifid_instr = buf_q;
              if (PCWrite) pc_d = pc_q + PC_STEP;
              state_d = REQ;
            end
          end

          DROP: begin
            if (imem_rvalid) state_d = REQ;
          end

          default: state_d = IDLE;
        endcase
      end
    end
  end

  assign imem_req    = (state_q == REQ);
  assign imem_addr   = pc_q;
  assign fetch_stall = fetch_stall_q;

  fetch_stage_if_id_reg #(
    .XLEN      (XLEN),
    .NOP_INSTR (NOP_INSTR)
  ) if_id_reg (
    .clock   (clock),
    .reset   (reset),
    .we_i    (ifid_we),
    .flush_i (ifid_flush),
    .pc_i    (pc_q),
    .instr_i (ifid_instr),
    .valid_i (ifid_valid),
    .pc_o    (if_id_pc),
    .instr_o (if_id_instr),
    .valid_o (if_id_valid)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters, advancing only on enabled cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (enable) begin
      if (fetch_stall_q && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
      if (if_id_flush && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign fetch_stall_cnt = stall_cnt_q;
  assign flush_cnt       = flush_cnt_q;
`endif

endmodule : fetch_stage
